clk_domain_gen: RTL
===================

// Module: clk_domain_gen
// PURPOSE
//   Multi-channel programmable clock divider. It generates NUM_CH phase-aligned, 50%-duty divided
//   clocks for the imem/dmem/regfile/processor domains from the single board clock.
//   Divide ratios and per-channel inversion are reloadable at run time through a glitch-free
//   drain/realign handshake. Sits at the top level beside the memories, regfile and processor.
// PARAMETERS
//   NUM_CH      4        number of divided clock channels
//   CNT_W       8        width of half-period counters / ratio fields
//   RESET_HALF  2        half-period (in clock cycles) of every channel after reset (divide-by-4)
//   RESET_INV   4'b1100  per-channel output inversion after reset (bit i -> channel i)
// PORTS
//   clock     in   1             board clock; all state on rising edge
//   reset     in   1             asynchronous, active-high reset
//   half_sel  in   NUM_CH*CNT_W  requested half-periods; channel i = half_sel[i*CNT_W +: CNT_W]
//   inv_sel   in   NUM_CH        requested output inversion mask
//   load      in   1             request to apply half_sel/inv_sel (sampled each cycle)
//   busy      out  1             reload in progress; further load ignored
//   load_ack  out  1             1-cycle pulse: new settings active, channels realigned
//   clk_out   out  NUM_CH        divided clocks (registered, glitch-free)
//   tick      out  NUM_CH        1-cycle pulse in the cycle clk_out[i] raw level goes 0->1
// BEHAVIOUR
//   Reset (async): active half H[i]=RESET_HALF, inv[i]=RESET_INV[i], cnt=0, raw=0,
//     clk_out=RESET_INV, tick=0, busy=0, load_ack=0, state=IDLE; pending reload aborted.
//   Channel i, H>0: cnt counts 0..H-1; when cnt==H-1: raw toggles, cnt<=0.
//     Output period = 2*H cycles, duty exactly 50%; clk_out[i]=raw[i]^inv[i], registered.
//     First raw rise occurs H cycles after reset deasserts. tick[i] asserts in the same cycle
//     clk_out reflects the rise. It does not depend on inversion.
//   Channel i, H==0: disabled; raw held 0, clk_out[i]=inv[i], tick[i] never asserts.
//   All channels with equal H share an identical phase at all times. No counter overflow is
//     possible: H max = 2^CNT_W-1.
//   FSM states IDLE -> DRAIN -> ALIGN -> IDLE.
//     IDLE: load=1 captures half_sel/inv_sel into shadow regs and sets busy=1 next cycle -> DRAIN.
//     DRAIN: channels keep running. A channel parks instead of rising when raw==0 and cnt==H-1,
//       so it holds raw=0 and cnt=0. A full low half-period is always completed; no runt pulse.
//       H==0 channels count as parked immediately. When all channels are parked -> ALIGN.
//     ALIGN (1 cycle): H<=shadow H, inv<=shadow inv, cnt<=0, raw<=0, parked cleared.
//       load_ack=1 for this cycle only; busy drops the following cycle -> IDLE.
//       clk_out may step only in ALIGN, if inversion changes, as a single clean transition.
//   After ALIGN, every enabled channel's first rise occurs exactly H_new cycles later,
//     simultaneously for channels with equal H_new.
//   load asserted while busy=1 is ignored (no queueing). load held high re-triggers only after
//     returning to IDLE.
//   Drain latency is at most 2*max(H_old) cycles. A reload with all H_old==0 reaches ALIGN on
//     the cycle after capture.
//   Reset during DRAIN/ALIGN: immediate return to reset values; shadow contents are discarded.
// TESTING
//   1. Reset, defaults -> ch0/1 clk_out period 4 cycles, 0 at reset; ch2/3 are inverted copies;
//      tick every 4 cycles, first at cycle 2.
//   2. load with half_sel={8'd1,8'd3,8'd0,8'd5}, inv_sel=0 mid high-phase -> no pulse shorter
//      than old half; load_ack once; then ch0 period 10, ch1 disabled low, ch2 period 6,
//      ch3 period 2; all rise 1/3/5 cycles after ALIGN.
//   3. load pulses while busy -> ignored; only first settings applied; exactly one load_ack.
//   4. All channels H=0 then load to H=7 -> ALIGN the cycle after capture; rise 7 cycles later.
//   5. Assert reset during DRAIN -> outputs back to reset values asynchronously; busy=0;
//      after release, behaviour matches test 1.
//   6. Max ratio H=255 on one channel, 1 on others -> period 510 without wrap error;
//      rises coincide every 510 cycles.

Source files
------------

// File: rtl/clk_domain_gen.sv
// Multi-channel programmable clock divider with glitch-free reload.
// Ratios/inversion are swapped only after every channel has parked low, so that all channels realign together.
module clk_domain_gen #(
    parameter int                CNT_W      = 8,
    parameter int                NUM_CH     = 4,
    parameter int                RESET_HALF = 2,
    parameter logic [NUM_CH-1:0] RESET_INV  = 4'b1100
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_CH*CNT_W-1:0] half_sel,
    input  logic [NUM_CH-1:0]       inv_sel,
    input  logic                    load,
    output logic                    busy,
    output logic                    load_ack,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick,
    output logic [1:0]              dbg_state_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, ALIGN = 2'd2} state_t;

    localparam logic [CNT_W-1:0] ZERO = '0;
    localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_q;
    logic [CNT_W-1:0]  half_q    [NUM_CH];
    logic [CNT_W-1:0]  half_d    [NUM_CH];
    logic [CNT_W-1:0]  cnt_q     [NUM_CH];
    logic [CNT_W-1:0]  cnt_d     [NUM_CH];
    logic [CNT_W-1:0]  sh_half_q [NUM_CH];
    logic [NUM_CH-1:0] raw_q, raw_d;
    logic [NUM_CH-1:0] inv_q, inv_d;
    logic [NUM_CH-1:0] parked_q, parked_d;
    logic [NUM_CH-1:0] sh_inv_q;
    logic [NUM_CH-1:0] clk_out_q, tick_q;
    logic              busy_q, ack_q;
    logic              draining, all_parked, align_go;

    assign draining = (state_q == DRAIN);

    always_comb begin
        all_parked = 1'b1;
        raw_d      = raw_q;
        parked_d   = parked_q;
        inv_d      = inv_q;
        for (int i = 0; i < NUM_CH; i++) begin
            half_d[i] = half_q[i];
            cnt_d[i]  = cnt_q[i];
            if (half_q[i] == ZERO) begin
                raw_d[i]    = 1'b0;
                cnt_d[i]    = ZERO;
                parked_d[i] = draining;
            end else if (parked_q[i]) begin
                raw_d[i] = 1'b0;
                cnt_d[i] = ZERO;
            end else if (cnt_q[i] == half_q[i] - ONE) begin
                cnt_d[i] = ZERO;
                // While draining, a channel about to rise parks instead, so its low half is never cut short.
                if (draining && !raw_q[i]) parked_d[i] = 1'b1;
                else                       raw_d[i]    = ~raw_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + ONE;
            end
            if (!parked_d[i]) all_parked = 1'b0;
        end
        align_go = draining && all_parked;
        if (align_go) begin
            inv_d    = sh_inv_q;
            raw_d    = '0;
            parked_d = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                half_d[i] = sh_half_q[i];
                cnt_d[i]  = ZERO;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                half_q[i]    <= CNT_W'(RESET_HALF);
                cnt_q[i]     <= ZERO;
                sh_half_q[i] <= ZERO;
            end
            raw_q     <= '0;
            inv_q     <= RESET_INV;
            parked_q  <= '0;
            sh_inv_q  <= '0;
            clk_out_q <= RESET_INV;
            tick_q    <= '0;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
            state_q   <= IDLE;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                half_q[i] <= half_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            raw_q     <= raw_d;
            inv_q     <= inv_d;
            parked_q  <= parked_d;
            clk_out_q <= raw_d ^ inv_d;
            tick_q    <= raw_d & ~raw_q;
            ack_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            sh_half_q[i] <= half_sel[i*CNT_W +: CNT_W];
                        end
                        sh_inv_q <= inv_sel;
                        busy_q   <= 1'b1;
                        state_q  <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (align_go) begin
                        ack_q   <= 1'b1;
                        state_q <= ALIGN;
                    end
                end
                ALIGN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign clk_out     = clk_out_q;
    assign tick        = tick_q;
    assign busy        = busy_q;
    assign load_ack    = ack_q;
    assign dbg_state_o = state_q;
endmodule
